// File: rtl/approx_sum_corrector_if.sv
// Operand/approx-sum request channel and corrected-result response channel
// between an approximate adder under test and its correction checker.
interface approx_sum_corrector_if #(
  parameter int N = 16,
  parameter int M = 4
);
  localparam int NSEG = N / M;

  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in1;
  logic [N-1:0]    in2;
  logic [N:0]      approx_res;
  logic            out_valid;
  logic            out_ready;
  logic [N:0]      exact_res;
  logic [NSEG-1:0] err_mask;
  logic            err_flag;
  logic [N:0]      err_mag;

  modport master (
    output in_valid, in1, in2, approx_res, out_ready,
    input  in_ready, out_valid, exact_res, err_mask, err_flag, err_mag
  );

  modport slave (
    input  in_valid, in1, in2, approx_res, out_ready,
    output in_ready, out_valid, exact_res, err_mask, err_flag, err_mag
  );
endinterface

// File: rtl/approx_sum_corrector.sv
// Rebuilds the exact sum of two operands one M-bit segment per cycle, compares it
// against an approximate adder's result and keeps saturating accuracy statistics.
module approx_sum_corrector #(
  parameter int N     = 16,
  parameter int M     = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  approx_sum_corrector_if.slave bus,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     op_cnt,
  output logic [CNT_W-1:0]     err_cnt
);
  localparam int NSEG = N / M;
  localparam int KW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SCAN, FINAL, DONE} state_e;

  state_e          state_q;
  logic [N-1:0]    a_q, b_q;
  logic [N:0]      ap_q;
  logic            carry_q;
  logic [KW-1:0]   k_q;
  logic [N:0]      exact_q;
  logic [NSEG-1:0] mask_q;
  logic            flag_q;
  logic [N:0]      mag_q;
  logic            in_ready_q, out_valid_q;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d, err_cnt_q, err_cnt_d;

  logic [M-1:0]    seg_a, seg_b, seg_ap;
  logic [M:0]      seg_sum;
  logic [N:0]      exact_full;
  logic [N+1:0]    diff, diff_neg;
  logic [N:0]      mag_d;
  logic            hs;

  always_comb begin
    seg_a      = a_q[int'(k_q)*M +: M];
    seg_b      = b_q[int'(k_q)*M +: M];
    seg_ap     = ap_q[int'(k_q)*M +: M];
    seg_sum    = {1'b0, seg_a} + {1'b0, seg_b} + {{M{1'b0}}, carry_q};
    // Final carry is still in carry_q while FINAL writes it into bit N.
    exact_full = {carry_q, exact_q[N-1:0]};
    diff       = {1'b0, exact_full} - {1'b0, ap_q};
    diff_neg   = '0 - diff;
    mag_d      = diff[N+1] ? diff_neg[N:0] : diff[N:0];
  end

  assign hs = (state_q == DONE) && out_valid_q && bus.out_ready;

  always_comb begin
    op_cnt_d  = op_cnt_q;
    err_cnt_d = err_cnt_q;
    if (stat_clr) begin
      op_cnt_d  = '0;
      err_cnt_d = '0;
    end else if (hs) begin
      if (op_cnt_q != CNT_MAX) op_cnt_d = op_cnt_q + 1'b1;
      if (flag_q && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      ap_q        <= '0;
      carry_q     <= 1'b0;
      k_q         <= '0;
      exact_q     <= '0;
      mask_q      <= '0;
      flag_q      <= 1'b0;
      mag_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      op_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      op_cnt_q  <= op_cnt_d;
      err_cnt_q <= err_cnt_d;
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.in1;
            b_q        <= bus.in2;
            ap_q       <= bus.approx_res;
            carry_q    <= 1'b0;
            k_q        <= '0;
            mask_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SCAN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        SCAN: begin
          exact_q[int'(k_q)*M +: M] <= seg_sum[M-1:0];
          carry_q                   <= seg_sum[M];
          mask_q[k_q]               <= (seg_sum[M-1:0] != seg_ap);
          k_q                       <= k_q + 1'b1;
          if (k_q == KW'(NSEG - 1)) state_q <= FINAL;
        end
        FINAL: begin
          exact_q[N] <= carry_q;
          flag_q     <= (|mask_q) | (carry_q != ap_q[N]);
          mag_q      <= mag_d;
          state_q    <= DONE;
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.exact_res = exact_q;
  assign bus.err_mask  = mask_q;
  assign bus.err_flag  = flag_q;
  assign bus.err_mag   = mag_q;
  assign op_cnt        = op_cnt_q;
  assign err_cnt       = err_cnt_q;
endmodule
